// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, small/big sigma helpers and the schedule FSM state type.
package sha256_pkg;

  localparam int WORD_W      = 32;
  localparam int ROUNDS      = 64;
  localparam int BLOCK_WORDS = 16;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } sched_state_e;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Big sigmas belong to the compression round; kept here so both sides share one table.
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// Block-input and schedule-output streams of sha256_msg_schedule.
// Optional out_k lane is present when SHA256_SCHED_K_OUT_EN is defined.
interface sha256_msg_schedule_if;
  // Both streams use valid/ready: a word moves on any rising edge where valid and ready
  // are both high; valid may not depend on ready, and the payload is stable while valid waits.
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_w;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_w;
  logic [5:0]               out_idx;
  logic                     out_last;
  logic                     busy;
  sha256_pkg::sched_state_e dbg_state;
`ifdef SHA256_SCHED_K_OUT_EN
  logic [31:0]              out_k;

  modport master (
    input  in_valid, in_w, out_ready,
    output in_ready, out_valid, out_w, out_idx, out_last, busy, dbg_state, out_k
  );
  modport slave (
    output in_valid, in_w, out_ready,
    input  in_ready, out_valid, out_w, out_idx, out_last, busy, dbg_state, out_k
  );
`else
  modport master (
    input  in_valid, in_w, out_ready,
    output in_ready, out_valid, out_w, out_idx, out_last, busy, dbg_state
  );
  modport slave (
    output in_valid, in_w, out_ready,
    input  in_ready, out_valid, out_w, out_idx, out_last, busy, dbg_state
  );
`endif
endinterface

// File: rtl/sha256_sched_word.sv
// One message-schedule step: next W from the oldest window taps r[0], r[1], r[9], r[14].
module sha256_sched_word
  import sha256_pkg::*;
(
  input  logic [31:0] w0_i,
  input  logic [31:0] w1_i,
  input  logic [31:0] w9_i,
  input  logic [31:0] w14_i,
  output logic [31:0] w_o
);
  assign w_o = sig1(w14_i) + w9_i + sig0(w1_i) + w0_i;
endmodule

// File: rtl/sha256_msg_schedule.sv
// Loads 16 message words, then streams W[0..63] with round index; SHA256_SCHED_K_OUT_EN
// adds the matching round constant on out_k.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  sha256_msg_schedule_if.master bus
);
  sched_state_e state_q;
  logic [3:0]   cnt_q;
  logic [5:0]   t_q;
  logic [31:0]  win_q [16];
  logic [31:0]  win_d [16];
  logic [31:0]  w_next;
  logic         in_fire;
  logic         out_fire;

  assign in_fire  = bus.in_valid  && (state_q == LOAD);
  assign out_fire = bus.out_ready && (state_q == EMIT);

  sha256_sched_word u_word (
    .w0_i  (win_q[0]),
    .w1_i  (win_q[1]),
    .w9_i  (win_q[9]),
    .w14_i (win_q[14]),
    .w_o   (w_next)
  );

  // Window holds W[t..t+15] during EMIT, so r[0] is always the word on offer.
  always_comb begin
    win_d = win_q;
    if (in_fire) begin
      win_d[cnt_q] = bus.in_w;
    end else if (out_fire) begin
      for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
      win_d[15] = w_next;
    end
  end

  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      t_q     <= '0;
    end else begin
      case (state_q)
        LOAD: if (bus.in_valid) begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_q <= EMIT;
        end
        EMIT: if (bus.out_ready) begin
          t_q <= t_q + 6'd1;
          if (t_q == 6'd63) state_q <= LOAD;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_w     = win_q[0];
  assign bus.out_idx   = t_q;
  assign bus.out_last  = (state_q == EMIT) && (t_q == 6'd63);
  assign bus.busy      = (state_q == EMIT) || (cnt_q != 4'd0);
  assign bus.dbg_state = state_q;
`ifdef SHA256_SCHED_K_OUT_EN
  assign bus.out_k     = K[t_q];
`endif

endmodule
